// File: rtl/weight_sram_ctrl.sv
// weight_sram_ctrl
// Burst initiator for the 16384x18 weight SRAM wrapper (one-cycle read latency).
// Accepts write/read burst commands, turns the wr_* stream into SRAM write
// strobes and returns read data on the rd_* stream through a 2-entry skid FIFO.
//
// Ports:
//   clk, rst            clock (also the SRAM CK), synchronous active-high reset
//   cmd_valid/ready     burst command handshake; cmd_write, cmd_base, cmd_len
//   wr_valid/ready/data write data stream (consumed only in WRITE)
//   rd_valid/ready/data read data stream (FIFO head)
//   busy, done          state != IDLE; one-cycle pulse at burst completion
//   sram_cs/oe/web/a/di SRAM strobes, address and write data
//   sram_do             SRAM read data, valid the cycle after a read issue
module weight_sram_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              sram_cs,
  output logic              sram_oe,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_di,
  input  logic [DATA_W-1:0] sram_do
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W:0]   remaining_reg;   // writes left (WRITE) or pops left (READ)
  logic [ADDR_W:0]   issue_left_reg;  // read issues still to send
  logic              inflight_reg;    // a read was issued last cycle
  logic [ADDR_W-1:0] a_hold_reg;
  logic [DATA_W-1:0] di_hold_reg;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              rd_ptr_reg;
  logic              wr_ptr_reg;
  logic [1:0]        occ_reg;

  logic accept;
  logic wr_fire;
  logic rd_issue;
  logic pop;
  logic push;
  logic last_word;

  // Handshake-facing outputs are forced low during reset so the consumer sees
  // a clean idle interface in the reset cycle itself, not only after it.
  assign cmd_ready = (state_reg == IDLE) && !rst;
  assign wr_ready  = (state_reg == WRITE) && !rst;
  assign rd_valid  = (occ_reg != 2'd0) && !rst;
  assign busy      = (state_reg != IDLE) && !rst;
  assign done      = (state_reg == DONE) && !rst;
  assign sram_oe   = (state_reg == READ) && !rst;
  assign rd_data   = fifo_mem[rd_ptr_reg];

  assign accept    = cmd_valid && cmd_ready;
  assign wr_fire   = wr_valid && wr_ready;
  assign pop       = rd_valid && rd_ready;
  assign push      = inflight_reg;
  assign last_word = (remaining_reg == (ADDR_W+1)'(1));

  // Issue only if, after this cycle, buffered + in-flight words stay <= 2.
  // occ + inflight - pop + 1 <= 2 is rearranged to avoid a negative term.
  assign rd_issue = !rst && (state_reg == READ) && (issue_left_reg != '0) &&
                    (({1'b0, occ_reg} + {2'b00, inflight_reg} + 3'd1) <=
                     (3'd2 + {2'b00, pop}));

  assign sram_cs  = wr_fire || rd_issue;
  assign sram_web = !wr_fire;
  // Address and data hold their last driven value between accesses.
  assign sram_a   = sram_cs ? addr_reg : a_hold_reg;
  assign sram_di  = wr_fire ? wr_data : di_hold_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0)   state_next = DONE;
          else if (cmd_write)  state_next = WRITE;
          else                 state_next = READ;
        end
      end
      WRITE:   if (wr_fire && last_word) state_next = DONE;
      READ:    if (pop && last_word)     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      remaining_reg  <= '0;
      issue_left_reg <= '0;
      inflight_reg   <= 1'b0;
      a_hold_reg     <= '0;
      di_hold_reg    <= '0;
      rd_ptr_reg     <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      occ_reg        <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg       <= cmd_base;
        remaining_reg  <= cmd_len;
        issue_left_reg <= cmd_len;
      end else begin
        // Address wraps naturally modulo 2^ADDR_W.
        if (wr_fire || rd_issue) addr_reg <= addr_reg + ADDR_W'(1);
        if (rd_issue)            issue_left_reg <= issue_left_reg - (ADDR_W+1)'(1);
        if (wr_fire || pop)      remaining_reg <= remaining_reg - (ADDR_W+1)'(1);
      end
      if (sram_cs) a_hold_reg  <= addr_reg;
      if (wr_fire) di_hold_reg <= wr_data;
      inflight_reg <= rd_issue;
      if (push) begin
        fifo_mem[wr_ptr_reg] <= sram_do;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_reg + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_weight_sram_ctrl.sv
// tb_weight_sram_ctrl
// Directed bench for weight_sram_ctrl with a behavioural 16384x18 SRAM
// (one-cycle read latency). Prints one line per SRAM write and per read pop.
module tb_weight_sram_ctrl;
  localparam int AW = 14;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic          sram_cs, sram_oe, sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do = '0;

  always #5 clk = ~clk;

  weight_sram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
    .sram_a(sram_a), .sram_di(sram_di), .sram_do(sram_do)
  );

  // SRAM model
  logic [DW-1:0] mem [0:16383];
  always @(posedge clk) begin
    if (sram_cs && !sram_web) mem[sram_a] <= sram_di;
    if (sram_cs && sram_web)  sram_do <= mem[sram_a];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor
  int wa_q[$], wd_q[$], wc_q[$], ra_q[$], rd_q[$], rc_q[$], dn_q[$];
  int acc_cnt = 0, cs_cnt = 0, issued = 0, popped = 0, max_out = 0;

  always @(negedge clk) begin
    if (sram_cs && !sram_web) begin
      wa_q.push_back(int'(sram_a)); wd_q.push_back(int'(sram_di)); wc_q.push_back(cyc);
      $display("write cyc=%0d a=%h d=%h", cyc, sram_a, sram_di);
    end
    if (sram_cs && sram_web) begin
      ra_q.push_back(int'(sram_a)); issued++;
    end
    if (sram_cs) cs_cnt++;
    if (rd_valid && rd_ready) begin
      rd_q.push_back(int'(rd_data)); rc_q.push_back(cyc); popped++;
      $display("pop   cyc=%0d d=%h", cyc, rd_data);
    end
    if (issued - popped > max_out) max_out = issued - popped;
    if (done) dn_q.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_cnt++;
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); ra_q.delete();
    rd_q.delete(); rc_q.delete(); dn_q.delete();
    acc_cnt = 0; cs_cnt = 0; issued = 0; popped = 0; max_out = 0;
  endtask

  // Stream drivers: rd_ready mode (0 off, 1 always, 2 pattern), write source queue
  int          wsrc[$];
  bit          gap_mode = 1'b0;
  int          wph = 0;
  int          rr_mode = 0;
  int          rr_i = 0;
  logic [15:0] rr_pat = 16'b1011_0010_1110_0101;

  always begin
    @(posedge clk); #1;
    rd_ready = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? rr_pat[rr_i % 16] : 1'b0;
    rr_i++;
    if (wsrc.size() > 0) begin
      wr_data  = DW'(wsrc[0]);
      wr_valid = gap_mode ? (wph % 3 == 0) : 1'b1;
      wph++;
    end else begin
      wr_valid = 1'b0;
    end
    @(negedge clk);
    if (wr_valid && wr_ready) void'(wsrc.pop_front());
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input bit w, input int base, input int len, output int acc);
    int n = 0;
    cmd_write = w; cmd_base = AW'(base); cmd_len = (AW+1)'(len); cmd_valid = 1'b1;
    acc = -1;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      n++;
      tick();
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc >= 0), 1);
    $display("cmd   cyc=%0d write=%0d base=%h len=%0d", acc, w, base, len);
  endtask

  task automatic wait_done(input int maxc, input bit spam, output int dc);
    int n = 0;
    dc = -1;
    while (dc < 0 && n < maxc) begin
      @(negedge clk);
      if (done) dc = cyc;
      n++;
      tick();
      cmd_valid = spam && (n % 2 == 0) && (dc < 0);
    end
    cmd_valid = 1'b0;
    check("done_seen", 32'(dc >= 0), 1);
  endtask

  task automatic do_write(input int base, input int len, input int d0, input int step,
                          input bit spam, output int acc, output int dc);
    clear_log();
    wph = 0;
    for (int i = 0; i < len; i++) wsrc.push_back(d0 + i * step);
    send_cmd(1'b1, base, len, acc);
    wait_done(200, spam, dc);
  endtask

  task automatic do_read(input int base, input int len, input int mode,
                         output int acc, output int dc);
    clear_log();
    rr_mode = mode;
    send_cmd(1'b0, base, len, acc);
    wait_done(300, 1'b0, dc);
    rr_mode = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dc, n;
    // Reset behaviour
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(done), 0);
    check("rst_sram_cs", 32'(sram_cs), 0);
    check("rst_sram_web", 32'(sram_web), 1);
    check("rst_sram_oe", 32'(sram_oe), 0);
    check("rst_sram_a", 32'(sram_a), 0);
    check("rst_sram_di", 32'(sram_di), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    tick();

    // Write 0x10..0x13 with data 1..4, wr_valid continuous
    do_write('h10, 4, 1, 1, 1'b0, acc, dc);
    check("w1_count", wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      check($sformatf("w1_addr%0d", i), wa_q[i], 'h10 + i);
      check($sformatf("w1_data%0d", i), wd_q[i], 1 + i);
      check($sformatf("w1_cyc%0d", i), wc_q[i], acc + 1 + i);
    end
    check("w1_done_cyc", dc, acc + 5);

    // Read it back with rd_ready high
    do_read('h10, 4, 1, acc, dc);
    check("r1_count", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      check($sformatf("r1_data%0d", i), rd_q[i], 1 + i);
      check($sformatf("r1_cyc%0d", i), rc_q[i], acc + 3 + i);
      check($sformatf("r1_addr%0d", i), ra_q[i], 'h10 + i);
    end
    check("r1_done_cyc", dc, acc + 7);

    // 16-word read with irregular rd_ready
    do_write('h100, 16, 'h2A000, 7, 1'b0, acc, dc);
    do_read('h100, 16, 2, acc, dc);
    check("r16_count", rd_q.size(), 16);
    for (int i = 0; i < 16 && i < rd_q.size(); i++)
      check($sformatf("r16_data%0d", i), rd_q[i], 'h2A000 + i * 7);
    check("r16_issued", issued, 16);
    check("r16_outstanding_le2", 32'(max_out <= 2), 1);
    check("r16_done_after_pop", dc, rc_q[$] + 1);

    // Address wrap
    do_write('h3FFE, 4, 'h30000, 1, 1'b0, acc, dc);
    check("wrap_w_count", wa_q.size(), 4);
    for (int i = 0; i < 4 && i < wa_q.size(); i++)
      check($sformatf("wrap_w_addr%0d", i), wa_q[i], (i < 2) ? 'h3FFE + i : i - 2);
    do_read('h3FFE, 4, 1, acc, dc);
    check("wrap_r_count", rd_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      check($sformatf("wrap_r_addr%0d", i), ra_q[i], (i < 2) ? 'h3FFE + i : i - 2);
      check($sformatf("wrap_r_data%0d", i), rd_q[i], 'h30000 + i);
    end

    // Zero-length bursts
    do_write('h55, 0, 0, 0, 1'b0, acc, dc);
    check("len0w_done_cyc", dc, acc + 1);
    check("len0w_cs", cs_cnt, 0);
    @(negedge clk);
    check("len0w_ready_back", 32'(cmd_ready), 1);
    tick();
    do_read('h55, 0, 1, acc, dc);
    check("len0r_done_cyc", dc, acc + 1);
    check("len0r_cs", cs_cnt, 0);
    @(negedge clk);
    check("len0r_ready_back", 32'(cmd_ready), 1);
    tick();

    // Gapped write stream with cmd_valid pulses during the burst
    gap_mode = 1'b1;
    do_write('h200, 5, 'h111, 'h111, 1'b1, acc, dc);
    gap_mode = 1'b0;
    check("gap_count", wa_q.size(), 5);
    check("gap_accepts", acc_cnt, 1);
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      check($sformatf("gap_addr%0d", i), wa_q[i], 'h200 + i);
      check($sformatf("gap_data%0d", i), wd_q[i], 'h111 * (i + 1));
      if (i > 0) check($sformatf("gap_spacing%0d", i), wc_q[i] - wc_q[i-1], 3);
    end

    // Reset in the middle of a read burst
    do_write('h300, 8, 'h1F000, 1, 1'b0, acc, dc);
    clear_log();
    rr_mode = 1;
    send_cmd(1'b0, 'h300, 8, acc);
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) n++;
      if (n < 3) tick();
    end
    check("mid_pops_reached", n, 3);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_rd_valid", 32'(rd_valid), 0);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_oe", 32'(sram_oe), 0);
    check("post_rst_cs", 32'(sram_cs), 0);
    check("post_rst_web", 32'(sram_web), 1);
    check("post_rst_a", 32'(sram_a), 0);
    check("post_rst_di", 32'(sram_di), 0);
    check("post_rst_rd_data", 32'(rd_data), 0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    repeat (3) tick();
    check("post_rst_no_done", dn_q.size(), 0);
    rr_mode = 0;
    do_read('h300, 8, 1, acc, dc);
    check("reread_count", rd_q.size(), 8);
    for (int i = 0; i < 8 && i < rd_q.size(); i++)
      check($sformatf("reread_data%0d", i), rd_q[i], 'h1F000 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_sram_ctrl.md
# weight_sram_ctrl

Burst initiator for the 16384×18 weight SRAM macro wrapper (CK/CS/OE/WEB/A/DI/DO, one-cycle read latency). It accepts write and read burst commands from the accelerator's weight loader and PE-array fetch logic. It converts valid/ready data streams into SRAM strobes, and buffers read data in a 2-entry skid FIFO so a stalled consumer never loses a word.

## Interface
- ADDR_W, 14, SRAM word address width
- DATA_W, 18, SRAM word width
- clk  in  1  clock; also drives the SRAM CK
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  burst command offered
- cmd_ready  out  1  controller idle, command accepted on cmd_valid&cmd_ready
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_base  in  ADDR_W  first word address
- cmd_len  in  ADDR_W+1  word count, 0..16384
- wr_valid / wr_ready / wr_data  in / out / DATA_W  write data stream
- rd_valid / rd_ready / rd_data  out / in / DATA_W  read data stream
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at burst completion
- sram_cs, sram_oe, sram_web  out  1 each  SRAM strobes
- sram_a  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data

## Operation
- States: IDLE, WRITE, READ, DONE. cmd_ready = (state==IDLE) & !rst.
- IDLE: on accept, latch addr=cmd_base and remaining=cmd_len. If cmd_len==0, go to DONE with no SRAM access. Otherwise go to WRITE or READ per cmd_write.
- WRITE: wr_ready=1. In a cycle with wr_valid:
  - sram_cs=1, sram_web=0, sram_a=addr, sram_di=wr_data, all combinational in that cycle; the SRAM writes at that clock edge.
  - addr increments and remaining decrements.
  - When the last word is written, go to DONE.
- READ:
  - sram_oe=1 for the whole state.
  - Issue (sram_cs=1, sram_web=1, sram_a=addr) when issues remain and occ + inflight − pop + 1 ≤ 2, where:
    - occ = FIFO occupancy;
    - inflight = a read was issued last cycle;
    - pop = rd_valid&rd_ready this cycle.
  - Data from the read issued in cycle c appears on sram_do in cycle c+1 and is pushed into the FIFO at the end of c+1.
  - rd_valid = occ!=0. rd_data = FIFO head.
  - Leave READ for DONE when cmd_len words have been popped.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W: 0x3FFF+1 = 0x0000, with no error.
- Outside an issue cycle: sram_cs=0, sram_web=1, sram_a and sram_di hold their last value. sram_oe=0 outside READ.
- cmd_valid while busy is ignored (not accepted). wr_valid outside WRITE is ignored. wr_ready=0 outside WRITE.

## Timing
- Reset values:
  - state=IDLE; FIFO empty; inflight=0.
  - rd_valid=0, done=0, busy=0, cmd_ready=0 while rst is high.
  - sram_cs=0, sram_web=1, sram_oe=0, sram_a=0, sram_di=0, rd_data=0.
- rst asserted mid-burst abandons the burst at the next edge. FIFO and inflight data are discarded. done is not pulsed. SRAM contents already written remain.
- Write: command accepted at edge T; first write strobe can occur in the cycle after T. 1 word/cycle with wr_valid held high. done is high in the cycle after the last write.
- Read: accepted at edge T.
  - First issue in cycle T+1.
  - Word 0 is on sram_do in T+2, and rd_valid=1 in T+3.
  - With rd_ready high, 1 word/cycle sustained.
  - done is high in the cycle after the last pop.
- Backpressure: at most 2 words are buffered or in flight beyond the consumer. FIFO never overflows. Words are delivered in address order with no loss or duplication.
- Simultaneous push and pop with occ==2 cannot occur, because the issue rule forbids it. Push and pop in the same cycle keep occ unchanged.

## Test plan
- Write base=0x0010, len=4, data 0x00001..0x00004, wr_valid continuous → write strobes at A=0x10..0x13, 4 consecutive cycles, done 1 cycle later. Then read the same range with rd_ready=1 → rd_valid first at T+3, data 1,2,3,4 on consecutive cycles, done after the last pop.
- Read len=16 with rd_ready toggling in a pseudo-random pattern → all 16 words in order. Never more than 2 reads outstanding beyond pops. sram_cs low whenever the issue rule fails.
- Wrap: write then read base=0x3FFE, len=4 → addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, with correct data returned.
- cmd_len=0 (read and write) → done exactly 1 cycle after accept, sram_cs never asserted, cmd_ready back to 1 in the following cycle.
- Write with wr_valid gaps (1-on/2-off) → strobes only on valid cycles. cmd_valid pulses during the burst are ignored (no second accept).
- Assert rst for 1 cycle after 3 of 8 read words are popped → all outputs at reset values next cycle, no done. A new read of the same range then returns the correct data from word 0.
